// File: rtl/dimmer_pkg.sv
// Shared types and constants for the multi-channel LED dimmer.
package dimmer_pkg;

  // Quadrature {A,B} states; Gray order Q00 -> Q01 -> Q11 -> Q10 is forward.
  typedef enum logic [1:0] {
    Q00 = 2'b00,
    Q01 = 2'b01,
    Q11 = 2'b11,
    Q10 = 2'b10
  } qstate_t;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_CW   = 2'd1,
    DIR_CCW  = 2'd2
  } dir_t;

  // Valid transitions per mechanical detent.
  localparam int DETENT = 4;

  // Ceiling log2, never less than 1 so it can size a vector directly.
  function automatic int clog2(input int unsigned value);
    int unsigned v;
    int          r;
    v = 1;
    r = 0;
    while (v < value) begin
      v = v << 1;
      r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/quad_decoder.sv
// Quadrature decoder: input synchronizers, Gray-code tracker and detent
// sub-count. Emits a one-cycle step pulse with its direction.
module quad_decoder
  import dimmer_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic a,
  input  logic b,
  output logic step,
  output dir_t dir
);

  localparam logic signed [3:0] DET_P = 4'(DETENT);
  localparam logic signed [3:0] DET_N = -DET_P;

  logic [1:0]        a_sync, b_sync;
  logic [1:0]        smp;
  qstate_t           state, state_nxt;
  logic              primed;
  logic signed [3:0] sub, sub_nxt, delta, sum;

  assign smp = {a_sync[1], b_sync[1]};

  // Two-stage synchronizers for the asynchronous encoder phases.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sync <= '0;
      b_sync <= '0;
    end else begin
      a_sync <= {a_sync[0], a};
      b_sync <= {b_sync[0], b};
    end
  end

  // Tracker state; the first sample after reset only seeds the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= Q00;
      primed <= 1'b0;
      sub    <= '0;
    end else begin
      state  <= state_nxt;
      primed <= 1'b1;
      sub    <= sub_nxt;
    end
  end

  // Classify the transition, accumulate it and fire on a full detent.
  always_comb begin
    state_nxt = qstate_t'(smp);
    sub_nxt   = sub;
    delta     = '0;
    sum       = sub;
    step      = 1'b0;
    dir       = DIR_NONE;
    if (primed) begin
      case (state)
        Q00:     if (smp == Q01) delta = 4'sd1; else if (smp == Q10) delta = -4'sd1;
        Q01:     if (smp == Q11) delta = 4'sd1; else if (smp == Q00) delta = -4'sd1;
        Q11:     if (smp == Q10) delta = 4'sd1; else if (smp == Q01) delta = -4'sd1;
        Q10:     if (smp == Q00) delta = 4'sd1; else if (smp == Q11) delta = -4'sd1;
        default: delta = '0;
      endcase
      sum = sub + delta;
      if (sum == DET_P) begin
        step    = 1'b1;
        dir     = DIR_CW;
        sub_nxt = '0;
      end else if (sum == DET_N) begin
        step    = 1'b1;
        dir     = DIR_CCW;
        sub_nxt = '0;
      end else begin
        sub_nxt = sum;
      end
    end
  end

endmodule

// File: rtl/led_dimmer_mc.sv
// Multi-channel encoder-controlled PWM LED dimmer.
// Build option: define LED_FADE_EN to ramp each active duty by 1 per period
// toward its target instead of loading the target directly.
module led_dimmer_mc
  import dimmer_pkg::*;
#(
  parameter int CH          = 4,
  parameter int LEDS_PER_CH = 6,
  parameter int PWM_W       = 8,
  parameter int PRESC_DIV   = 16,
  parameter int STEP        = 4,
  parameter int DEB_CYC     = 50000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enc_a,
  input  logic                        enc_b,
  input  logic                        enc_btn,
  output logic [CH*LEDS_PER_CH-1:0]   leds,
  output logic [clog2(CH)-1:0]        sel_ch,
  output logic [PWM_W-1:0]            sel_duty
);

  localparam int SEL_W = clog2(CH);
  localparam int PRE_W = clog2(PRESC_DIV);
  localparam int DEB_W = clog2(DEB_CYC);
  localparam int XW    = PWM_W + 1;
  localparam logic [XW-1:0] STEP_X   = XW'(STEP);
  localparam logic [XW-1:0] DUTY_MAX = {1'b0, {PWM_W{1'b1}}};

  logic             step;
  dir_t             dir;
  logic [1:0]       btn_sync;
  logic             btn_s, btn_deb, deb_accept, press;
  logic [DEB_W-1:0] deb_cnt;
  logic [PWM_W-1:0] target [CH];
  logic [PWM_W-1:0] active [CH];
  logic [PWM_W-1:0] duty_nxt;
  logic [XW-1:0]    cur_x, up_x, dn_x;
  logic [PRE_W-1:0] pre_cnt;
  logic             tick, wrap;
  logic [PWM_W-1:0] cnt;
  logic [CH-1:0]    pwm;

  quad_decoder u_quad (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (enc_a),
    .b     (enc_b),
    .step  (step),
    .dir   (dir)
  );

  assign btn_s      = btn_sync[1];
  assign deb_accept = (btn_s != btn_deb) && (deb_cnt == DEB_W'(DEB_CYC - 1));
  assign press      = deb_accept && btn_deb;

  // Synchronize the button and accept a new level once it has held long enough.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_sync <= '0;
      btn_deb  <= 1'b0;
      deb_cnt  <= '0;
    end else begin
      btn_sync <= {btn_sync[0], enc_btn};
      if (btn_s == btn_deb) begin
        deb_cnt <= '0;
      end else if (deb_accept) begin
        btn_deb <= btn_s;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  assign sel_duty = target[sel_ch];
  assign cur_x    = {1'b0, target[sel_ch]};
  assign up_x     = cur_x + STEP_X;
  assign dn_x     = cur_x - STEP_X;

  // Saturating step of the selected channel's target duty.
  always_comb begin
    duty_nxt = target[sel_ch];
    if (dir == DIR_CW)
      duty_nxt = (up_x > DUTY_MAX) ? '1 : up_x[PWM_W-1:0];
    else if (dir == DIR_CCW)
      duty_nxt = (cur_x < STEP_X) ? '0 : dn_x[PWM_W-1:0];
  end

  // A step lands on the pre-press channel even when a press coincides.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_ch <= '0;
      for (int unsigned k = 0; k < CH; k++) target[k] <= '0;
    end else begin
      if (step) target[sel_ch] <= duty_nxt;
      if (press) sel_ch <= (sel_ch == SEL_W'(CH - 1)) ? '0 : sel_ch + 1'b1;
    end
  end

  assign tick = (pre_cnt == PRE_W'(PRESC_DIV - 1));
  assign wrap = tick && (cnt == '1);

  // Prescaler and shared free-running PWM counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
      cnt     <= '0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
      if (tick) cnt <= cnt + 1'b1;
    end
  end

  // Shadow duties change only as the counter wraps, keeping periods whole.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < CH; k++) active[k] <= '0;
    end else if (wrap) begin
      for (int unsigned k = 0; k < CH; k++) begin
`ifdef LED_FADE_EN
        if (active[k] < target[k])      active[k] <= active[k] + 1'b1;
        else if (active[k] > target[k]) active[k] <= active[k] - 1'b1;
`else
        active[k] <= target[k];
`endif
      end
    end
  end

  // Registered per-channel compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm <= '0;
    else for (int unsigned k = 0; k < CH; k++) pwm[k] <= (cnt < active[k]);
  end

  // Fan each channel out to its LED group.
  always_comb begin
    leds = '0;
    for (int unsigned k = 0; k < CH; k++)
      leds[k*LEDS_PER_CH +: LEDS_PER_CH] = {LEDS_PER_CH{pwm[k]}};
  end

endmodule

// File: tb/tb_led_dimmer_mc.sv
// Self-checking bench for led_dimmer_mc with a behavioural duty/selection model.
module tb_led_dimmer_mc;

  localparam int CH    = 4;
  localparam int LPC   = 6;
  localparam int PWM_W = 8;
  localparam int PRESC = 1;
  localparam int STEP  = 4;
  localparam int DEB   = 20;
  localparam int PH    = 3;
  localparam int PER   = 256;
`ifdef LED_FADE_EN
  localparam int SETTLE = 30;
`else
  localparam int SETTLE = 2;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              enc_a = 1'b0;
  logic              enc_b = 1'b0;
  logic              enc_btn = 1'b1;
  logic [CH*LPC-1:0] leds;
  logic [1:0]        sel_ch;
  logic [PWM_W-1:0]  sel_duty;

  int n_checks = 0;
  int n_fail   = 0;
  int tgt [CH];
  int sel = 0;
  int meas [CH];
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  led_dimmer_mc #(
    .CH(CH), .LEDS_PER_CH(LPC), .PWM_W(PWM_W), .PRESC_DIV(PRESC),
    .STEP(STEP), .DEB_CYC(DEB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enc_a(enc_a), .enc_b(enc_b), .enc_btn(enc_btn),
    .leds(leds), .sel_ch(sel_ch), .sel_duty(sel_duty)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_ab(input logic [1:0] v);
    @(negedge clk);
    {enc_a, enc_b} = v;
    repeat (PH - 1) @(negedge clk);
  endtask

  function automatic void model_step(input bit cw);
    if (cw) tgt[sel] = (tgt[sel] + STEP > 255) ? 255 : tgt[sel] + STEP;
    else    tgt[sel] = (tgt[sel] - STEP < 0)   ? 0   : tgt[sel] - STEP;
  endfunction

  task automatic detent(input bit cw, input string tag);
    if (cw) begin set_ab(2'b01); set_ab(2'b11); set_ab(2'b10); set_ab(2'b00); end
    else    begin set_ab(2'b10); set_ab(2'b11); set_ab(2'b01); set_ab(2'b00); end
    model_step(cw);
    repeat (4) @(negedge clk);
    check(tag, sel_duty, tgt[sel]);
  endtask

  task automatic after_press(input string tag);
    sel = (sel + 1) % CH;
    check({tag, "_sel"}, sel_ch, sel);
    check({tag, "_duty"}, sel_duty, tgt[sel]);
  endtask

  task automatic press(input string tag);
    @(negedge clk);
    enc_btn = 1'b0;
    repeat (DEB + 6) @(negedge clk);
    enc_btn = 1'b1;
    repeat (DEB + 6) @(negedge clk);
    after_press(tag);
  endtask

  task automatic bouncy_press(input string tag);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); enc_btn = 1'b0;
      repeat ($urandom_range(1, DEB - 3)) @(negedge clk);
      enc_btn = 1'b1;
      repeat ($urandom_range(1, DEB - 3)) @(negedge clk);
    end
    enc_btn = 1'b0;
    repeat (DEB + 6) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      enc_btn = 1'b1;
      repeat ($urandom_range(1, DEB - 3)) @(negedge clk);
      enc_btn = 1'b0;
      repeat ($urandom_range(1, DEB - 3)) @(negedge clk);
    end
    enc_btn = 1'b1;
    repeat (DEB + 6) @(negedge clk);
    after_press(tag);
  endtask

  task automatic measure();
    int nonuni;
    logic [LPC-1:0] g;
    nonuni = 0;
    for (int k = 0; k < CH; k++) meas[k] = 0;
    repeat (PER) begin
      @(negedge clk);
      for (int k = 0; k < CH; k++) begin
        g = leds[k*LPC +: LPC];
        if (g == '1) meas[k]++;
        else if (g != '0) nonuni++;
      end
    end
    check("led_group_uniform", nonuni, 0);
  endtask

  initial begin
    int hi, rise_cyc, exp_mid, d_before, op, n;
    bit found;
    logic prev;
    for (int k = 0; k < CH; k++) tgt[k] = 0;

    // Reset values
    repeat (5) @(negedge clk);
    #1;
    check("rst_leds", leds, 0);
    check("rst_sel", sel_ch, 0);
    check("rst_duty", sel_duty, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (DEB + 10) @(negedge clk);

    // Four CW detents on channel 0
    for (int i = 0; i < 4; i++) detent(1'b1, "cw4");
    check("cw4_total", sel_duty, 16);
    repeat (SETTLE * PER + 4) @(negedge clk);
    measure();
    check("pwm_ch0_16", meas[0], 16);
    for (int k = 1; k < CH; k++) check("pwm_other_zero", meas[k], 0);

    // Target change mid-period stays invisible until the wrap
    found = 1'b0;
    prev = leds[0];
    for (int i = 0; i < 3 * PER && !found; i++) begin
      @(negedge clk);
      if (!prev && leds[0]) found = 1'b1;
      prev = leds[0];
    end
    check("mid_rise_found", found, 1);
    rise_cyc = cyc;
    repeat (20) @(negedge clk);
    detent(1'b1, "mid_cw");
    detent(1'b1, "mid_cw");
    hi = 0;
    while (cyc < rise_cyc + PER - 1) begin
      @(negedge clk);
      hi += int'(leds[0]);
    end
    check("mid_old_period_low", hi, 0);
    hi = 0;
    repeat (PER) begin
      @(negedge clk);
      hi += int'(leds[0]);
    end
`ifdef LED_FADE_EN
    exp_mid = 17;
`else
    exp_mid = tgt[0];
`endif
    check("mid_new_period", hi, exp_mid);

    // Clean presses: 1,2,3,0,1 then a bouncy press to 2
    for (int i = 0; i < 5; i++) press("press");
    bouncy_press("bouncy");

    // Step and press in the same cycle on channel 2
    set_ab(2'b01); set_ab(2'b11); set_ab(2'b10);
    @(negedge clk);
    enc_btn = 1'b0;
    repeat (DEB - 1) @(negedge clk);
    {enc_a, enc_b} = 2'b00;
    repeat (DEB + 6) @(negedge clk);
    enc_btn = 1'b1;
    repeat (DEB + 6) @(negedge clk);
    model_step(1'b1);
    after_press("simul");
    for (int i = 0; i < 3; i++) press("simul_back");
    check("simul_ch2", sel_duty, 4);

    // Invalid jumps and a half detent there and back
    d_before = tgt[sel];
    set_ab(2'b11); set_ab(2'b00); set_ab(2'b11); set_ab(2'b00);
    repeat (4) @(negedge clk);
    check("invalid_nostep", sel_duty, d_before);
    set_ab(2'b01); set_ab(2'b11); set_ab(2'b01); set_ab(2'b00);
    set_ab(2'b10); set_ab(2'b00);
    repeat (4) @(negedge clk);
    check("half_nostep", sel_duty, d_before);
    detent(1'b1, "after_invalid");

    // Saturation both ways
    for (int i = 0; i < 70; i++) detent(1'b1, "sat_up");
    check("sat_max", sel_duty, 255);
    for (int i = 0; i < 70; i++) detent(1'b0, "sat_dn");
    check("sat_min", sel_duty, 0);

    // Random mix of detents and presses
    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 3);
      case (op)
        0: detent(1'b1, "rnd_cw");
        1: detent(1'b0, "rnd_ccw");
        2: press("rnd_press");
        default: begin
          n = $urandom_range(3, 8);
          found = bit'($urandom_range(0, 1));
          for (int j = 0; j < n; j++) detent(found, "rnd_burst");
        end
      endcase
    end

    // Asynchronous reset while LEDs are lit
    for (int i = 0; i < 5; i++) detent(1'b1, "pre_rst");
    repeat (SETTLE * PER + 4) @(negedge clk);
    found = 1'b0;
    for (int i = 0; i < 2 * PER && !found; i++) begin
      @(negedge clk);
      if (leds != '0) found = 1'b1;
    end
    check("pre_rst_lit", found, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_leds", leds, 0);
    check("async_rst_sel", sel_ch, 0);
    check("async_rst_duty", sel_duty, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < CH; k++) tgt[k] = 0;
    sel = 0;
    repeat (DEB + 10) @(negedge clk);
    measure();
    for (int k = 0; k < CH; k++) check("post_rst_dark", meas[k], 0);
    detent(1'b1, "post_rst_cw");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/led_dimmer_mc.md
Name: led_dimmer_mc

Overview:
- Multi-channel successor to the single-channel encoder/PWM LED dimmer.
- A quadrature encoder adjusts the duty of the currently selected channel; the encoder push-button cycles channel selection.
- Each channel drives its own group of LEDs from a glitch-free, period-aligned PWM generator.
- Sits between the board encoder pins and the LED bank in the top level.

Parameters:
- CH, 4, number of independent PWM channels (≥2).
- LEDS_PER_CH, 6, LEDs driven in parallel by each channel.
- PWM_W, 8, duty and PWM counter width.
- PRESC_DIV, 16, clk cycles per PWM counter tick (≥1).
- STEP, 4, duty change per encoder detent.
- DEB_CYC, 50000, clk cycles the button must be stable to be accepted.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- enc_a  in  1  encoder phase A, asynchronous.
- enc_b  in  1  encoder phase B, asynchronous.
- enc_btn  in  1  encoder push-button, asynchronous, active-low.
- leds  out  CH*LEDS_PER_CH  LED drive; channel k occupies bits [k*LEDS_PER_CH +: LEDS_PER_CH].
- sel_ch  out  clog2(CH)  currently selected channel.
- sel_duty  out  PWM_W  target duty of the selected channel.

Behaviour:
- Reset: one clock (clk), asynchronous active-low reset (rst_n); all registers clear on rst_n low regardless of clk. leds=0, sel_ch=0, sel_duty=0, all target/active duties=0, all counters=0, decoder state taken from the first synchronized sample after release. Reset mid-operation aborts any pending step or press without generating an event.
- Inputs: each of enc_a, enc_b, enc_btn passes through a 2-FF synchronizer. Event latency from pin to register update is 3 clk.
- Quadrature decode: a 4-state machine tracks {A,B} in Gray order 00→01→11→10.
  - Each valid forward transition is +1 on a signed sub-count; each valid reverse transition is −1.
  - Invalid transitions (both bits change in one cycle) are ignored, and the state resyncs to the new sample.
  - Sub-count reaching +4 emits a one-cycle CW step; reaching −4 emits a one-cycle CCW step. The sub-count then clears.
  - A direction reversal mid-detent simply cancels out arithmetically.
- Button: the synchronized level must be stable for DEB_CYC consecutive cycles before the debounced level changes. A debounced high→low edge emits a one-cycle press.
- Selection: a press sets sel_ch to (sel_ch+1) mod CH; the value wraps from CH−1 to 0.
- Duty:
  - CW adds STEP to target[sel_ch], saturating at 2^PWM_W−1.
  - CCW subtracts STEP, saturating at 0.
  - Width-extend by one bit before comparing.
- Simultaneous step and press in the same cycle: the step applies to the old sel_ch, and sel_ch advances in that same cycle.
- sel_duty = target[sel_ch], combinational from registers.
- PWM generation:
  - The prescaler emits a tick every PRESC_DIV clk cycles.
  - A shared PWM_W-bit counter increments on each tick and wraps naturally.
  - Period = 2^PWM_W × PRESC_DIV clk cycles.
  - Channel k output is registered: high when cnt < active[k].
  - Duty 0 gives constantly low. Duty max gives high for 2^PWM_W−1 of 2^PWM_W slots.
- Shadowing: active[k] updates only on the tick where cnt wraps to 0, so no partial-period glitches occur. A target change takes effect at the next period start, at most one period later.

Optional Feature:
- Macro: LED_FADE_EN.
- Defined: at each period start, active[k] moves toward target[k] by exactly 1 (up or down). It holds when equal, so a 0→255 change takes 255 periods.
- Undefined: at each period start, active[k] is loaded directly from target[k].
- All ports and reset values are identical in both builds.

Decomposition:
- Shared package/include dimmer_pkg:
  - quadrature state encodings (Q00, Q01, Q11, Q10);
  - direction codes (DIR_NONE, DIR_CW, DIR_CCW);
  - detent threshold constant 4;
  - clog2 helper function.
- One natural sub-module: quad_decoder. It contains the synchronizers, the Gray state machine, and the detent sub-count, with output step pulse plus direction. It is instantiated once.
- Button debounce and the PWM logic stay in led_dimmer_mc.

Test Plan:
- Reset then 4 CW detents on sel_ch 0 with STEP=4, PRESC_DIV=1, PWM_W=8 → sel_duty=16. After the next period boundary, ch0 is high for 16 of every 256 cycles; other channels stay 0.
- 70 CW detents → sel_duty saturates at 255. Then 70 CCW detents → 0, with no wrap-around in either direction.
- 5 clean presses → sel_ch sequence 1,2,3,0,1. A press with bounces shorter than DEB_CYC produces exactly one increment.
- Step and press in the same cycle on sel_ch=2 → target[2] changes, target[3] is unchanged, sel_ch=3.
- Invalid {A,B} 00→11 jumps and a half-detent forward then back → no step is emitted, and sel_duty is unchanged.
- Change target mid-period → leds unchanged until cnt wraps. With LED_FADE_EN defined, 0→8 reaches duty 8 after 8 periods.
- Assert rst_n mid-period → leds go to 0 immediately, without waiting for a clk edge.
